// File: rtl/alu_pkg.sv
// Shared op codes and sequencer state encoding for the ALU / multiply-divide unit.
package alu_pkg;

   localparam logic [5:0] FN_SLL   = 6'd0;
   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIVU  = 6'd27;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_SLT   = 6'd42;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } mdState_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative 1-bit/cycle unsigned multiplier and restoring divider owning HI/LO.
module seq_muldiv_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             launchMul,
   input  logic             launchDiv,
   input  logic             launchDivZero,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output mdState_t         state,
   output logic             lastStep,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] accHi;
   logic [WIDTH-1:0] accLo;

   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   remShift;
   logic [WIDTH:0]   remDiff;
   logic [WIDTH-1:0] nextHi;
   logic [WIDTH-1:0] nextLo;

   // MUL: accHi:accLo is the running product, accLo starts as the multiplier.
   // DIV: accHi is the partial remainder, accLo shifts dividend out and quotient in.
   always_comb begin
      mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
      remShift = {accHi, accLo[WIDTH-1]};
      remDiff  = remShift - {1'b0, operand};
      nextHi   = '0;
      nextLo   = '0;
      if (state == MUL) begin
         nextHi = mulSum[WIDTH:1];
         nextLo = {mulSum[0], accLo[WIDTH-1:1]};
      end else begin
         nextHi = remDiff[WIDTH] ? remShift[WIDTH-1:0] : remDiff[WIDTH-1:0];
         nextLo = {accLo[WIDTH-2:0], ~remDiff[WIDTH]};
      end
   end

   assign lastStep = (state != IDLE) && (count == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         count   <= '0;
         operand <= '0;
         accHi   <= '0;
         accLo   <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launchMul) begin
                  operand <= opA;
                  accHi   <= '0;
                  accLo   <= opB;
                  count   <= CNT_W'(WIDTH - 1);
                  state   <= MUL;
               end else if (launchDiv) begin
                  operand <= opB;
                  accHi   <= '0;
                  accLo   <= opA;
                  count   <= CNT_W'(WIDTH - 1);
                  state   <= DIV;
               end else if (launchDivZero) begin
                  hi <= opA;
                  lo <= '1;
               end
            end
            MUL, DIV: begin
               accHi <= nextHi;
               accLo <= nextLo;
               count <= count - 1'b1;
               if (count == '0) begin
                  hi    <= nextHi;
                  lo    <= nextLo;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execution unit: registered single-cycle ALU ops plus iterative MULTU/DIVU into HI/LO.
module alu_muldiv_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             illegal
);

   localparam int SHAMT_W = $clog2(WIDTH);

   mdState_t         coreState;
   logic             coreLast;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   logic             launch;
   logic             opDone;
   logic             isMul;
   logic             isDiv;
   logic             isDivZero;
   logic             isIllegal;
   logic [WIDTH-1:0] aluResult;
   logic [SHAMT_W-1:0] shamt;

   // Handshake: start is accepted only on a cycle with busy==0 and is otherwise
   // dropped; done pulses for one cycle with result/flags, and busy falls that same cycle.
   assign busy   = (coreState != IDLE);
   assign launch = start & ~busy;
   assign shamt  = data_b[SHAMT_W-1:0];

   always_comb begin
      aluResult = '0;
      opDone    = 1'b1;
      isMul     = 1'b0;
      isDiv     = 1'b0;
      isDivZero = 1'b0;
      isIllegal = 1'b0;
      case (funct)
         FN_AND:   aluResult = data_a & data_b;
         FN_OR:    aluResult = data_a | data_b;
         FN_ADD:   aluResult = data_a + data_b;
         FN_SUB:   aluResult = data_a - data_b;
         FN_SLT:   aluResult[0] = $signed(data_a) < $signed(data_b);
         FN_SLL:   aluResult = data_a << shamt;
         FN_SRL:   aluResult = data_a >> shamt;
         FN_MFHI:  aluResult = hi;
         FN_MFLO:  aluResult = lo;
         FN_MULTU: begin
            isMul  = 1'b1;
            opDone = 1'b0;
         end
         FN_DIVU: begin
            if (data_b == '0) begin
               isDivZero = 1'b1;
            end else begin
               isDiv  = 1'b1;
               opDone = 1'b0;
            end
         end
         default:  isIllegal = 1'b1;
      endcase
   end

   seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk           (clk),
      .reset         (reset),
      .launchMul     (launch & isMul),
      .launchDiv     (launch & isDiv),
      .launchDivZero (launch & isDivZero),
      .opA           (data_a),
      .opB           (data_b),
      .state         (coreState),
      .lastStep      (coreLast),
      .hi            (hi),
      .lo            (lo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result      <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         illegal     <= 1'b0;
         if (coreLast) begin
            done   <= 1'b1;
            result <= '0;
         end else if (launch && opDone) begin
            done        <= 1'b1;
            result      <= aluResult;
            div_by_zero <= isDivZero;
            illegal     <= isIllegal;
         end
      end
   end

endmodule
